dmem_port_arbiter: RTL and testbench

Shares the single-port data memory between the CPU MEM stage and a secondary debug/DMA requester (UART memory dump and keyboard buffer writer). It sits between the MEM-stage memory path and the DMem block. Each cycle it selects one owner and drives the memory port from that owner. It returns synchronous read data to the requester that issued the read, and it stalls the pipeline while the CPU is denied the port. A starvation counter guarantees the secondary port progress under sustained CPU traffic.

---
 rtl/dmem_port_arbiter.sv | 105 ++++++++++
 tb/tb_dmem_port_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Single-port DMem arbiter between the CPU MEM stage and a debug/DMA requester.
// The CPU has priority. A streak counter forces a dbg slot after MAX_CPU_STREAK CPU wins.
module dmem_port_arbiter #(
  parameter int ADDR_W         = 14,
  parameter int DATA_W         = 32,
  parameter int MAX_CPU_STREAK = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] OWN_NONE   = 2'd0;
  localparam logic [1:0] OWN_CPU    = 2'd1;
  localparam logic [1:0] OWN_DBG    = 2'd2;
  localparam logic [3:0] STREAK_MAX = 4'(MAX_CPU_STREAK);

  logic [3:0]        r_streak;
  logic [1:0]        r_rd_owner;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dbg_rdata;

  logic              w_force_dbg;
  logic              w_cpu_win;
  logic              w_dbg_win;
  logic [1:0]        w_rd_owner_nxt;
  logic [3:0]        w_streak_nxt;

  assign w_force_dbg = (r_streak == STREAK_MAX);
  assign w_dbg_win   = dbg_req & (~cpu_req | w_force_dbg);
  assign w_cpu_win   = cpu_req & ~w_dbg_win;

  assign cpu_stall = cpu_req & ~w_cpu_win;
  assign dbg_gnt   = w_dbg_win;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_cpu_win) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (w_dbg_win) begin
      mem_en    = 1'b1;
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  always_comb begin
    w_rd_owner_nxt = OWN_NONE;
    if (w_cpu_win && !cpu_we)      w_rd_owner_nxt = OWN_CPU;
    else if (w_dbg_win && !dbg_we) w_rd_owner_nxt = OWN_DBG;
  end

  // Streak only counts CPU wins that actually made dbg wait.
  always_comb begin
    w_streak_nxt = r_streak;
    if (w_dbg_win || !dbg_req)              w_streak_nxt = '0;
    else if (w_cpu_win && !w_force_dbg)     w_streak_nxt = r_streak + 4'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_streak    <= '0;
      r_rd_owner  <= OWN_NONE;
      r_cpu_rdata <= '0;
      r_dbg_rdata <= '0;
    end else begin
      r_streak   <= w_streak_nxt;
      r_rd_owner <= w_rd_owner_nxt;
      if (r_rd_owner == OWN_CPU) r_cpu_rdata <= mem_rdata;
      if (r_rd_owner == OWN_DBG) r_dbg_rdata <= mem_rdata;
    end
  end

  // Return-cycle bypass so rdata is already correct while rvalid is high.
  assign cpu_rvalid = (r_rd_owner == OWN_CPU);
  assign dbg_rvalid = (r_rd_owner == OWN_DBG);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : r_cpu_rdata;
  assign dbg_rdata  = dbg_rvalid ? mem_rdata : r_dbg_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed plan items plus random traffic against a
// transaction-level model (priority rule, wait count, shadow memory).
module tb_dmem_port_arbiter;
  localparam int AW = 14;
  localparam int DW = 32;
  localparam int MAXS = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          cpu_req, cpu_we, dbg_req, dbg_we;
  logic [AW-1:0] cpu_addr, dbg_addr;
  logic [DW-1:0] cpu_wdata, dbg_wdata;
  logic          cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_en, mem_we;
  logic [DW-1:0] cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_CPU_STREAK(MAXS)) dut (
    .clk(clk), .rstn(rstn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // DMem stand-in: synchronous single-port, read data valid the cycle after issue.
  logic [DW-1:0] tmem [0:255];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) tmem[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= tmem[mem_addr[7:0]];
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: wait count of dbg, who read last cycle, shadow memory.
  int            m_wait;
  int            m_pend;   // 0 none, 1 cpu, 2 dbg
  logic [DW-1:0] m_pend_data, m_cpu_rd, m_dbg_rd;
  logic [DW-1:0] shadow [0:255];
  bit            e_cpu_win, e_dbg_win;

  task automatic model_reset();
    m_wait = 0; m_pend = 0; m_pend_data = '0; m_cpu_rd = '0; m_dbg_rd = '0;
  endtask

  task automatic cycle(input bit creq, input bit cwe, input logic [AW-1:0] caddr,
                       input logic [DW-1:0] cwd, input bit dreq, input bit dwe,
                       input logic [AW-1:0] daddr, input logic [DW-1:0] dwd);
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    bit ewe;
    @(negedge clk);
    cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    dbg_req = dreq; dbg_we = dwe; dbg_addr = daddr; dbg_wdata = dwd;
    #1;
    e_dbg_win = dreq && (!creq || m_wait >= MAXS);
    e_cpu_win = creq && !e_dbg_win;
    ea = e_cpu_win ? caddr : (e_dbg_win ? daddr : '0);
    ed = e_cpu_win ? cwd   : (e_dbg_win ? dwd   : '0);
    ewe = e_cpu_win ? cwe  : (e_dbg_win ? dwe   : 1'b0);
    chk("dbg_gnt", dbg_gnt, e_dbg_win);
    chk("cpu_stall", cpu_stall, creq && !e_cpu_win);
    chk("mem_en", mem_en, e_cpu_win || e_dbg_win);
    chk("mem_we", mem_we, ewe);
    chk("mem_addr", 32'(mem_addr), 32'(ea));
    chk("mem_wdata", mem_wdata, ed);
    if (m_pend == 1) m_cpu_rd = m_pend_data;
    if (m_pend == 2) m_dbg_rd = m_pend_data;
    chk("cpu_rvalid", cpu_rvalid, m_pend == 1);
    chk("dbg_rvalid", dbg_rvalid, m_pend == 2);
    chk("cpu_rdata", cpu_rdata, m_cpu_rd);
    chk("dbg_rdata", dbg_rdata, m_dbg_rd);
    m_pend = 0;
    if ((e_cpu_win || e_dbg_win) && !ewe) begin
      m_pend = e_cpu_win ? 1 : 2;
      m_pend_data = shadow[ea[7:0]];
    end
    if ((e_cpu_win || e_dbg_win) && ewe) shadow[ea[7:0]] = ed;
    if (!dreq || e_dbg_win) m_wait = 0;
    else if (m_wait < MAXS) m_wait++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  // Called right after a cycle() check, so reset lands before the next rising edge.
  task automatic do_reset(input int n);
    #1;
    rstn = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    model_reset();
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      chk("rst_cpu_stall", cpu_stall, 0);
      chk("rst_dbg_gnt", dbg_gnt, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_cpu_rvalid", cpu_rvalid, 0);
      chk("rst_dbg_rvalid", dbg_rvalid, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      chk("rst_dbg_rdata", dbg_rdata, 0);
    end
    rstn = 1'b1;
  endtask

  bit            c_hold, c_we, d_hold, d_we;
  logic [AW-1:0] c_addr, d_addr;
  logic [DW-1:0] c_wd, d_wd;

  initial begin
    for (int i = 0; i < 256; i++) begin tmem[i] = '0; shadow[i] = '0; end
    mem_rdata = '0;
    do_reset(3);
    idle(3);

    // CPU write then read-back
    cycle(1, 1, 14'h0010, 32'hDEADBEEF, 0, 0, '0, '0);
    cycle(1, 0, 14'h0010, '0, 0, 0, '0, '0);
    cycle(0, 0, '0, '0, 0, 0, '0, '0);
    chk("wr_rd_cpu_rvalid", cpu_rvalid, 1);
    chk("wr_rd_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    idle(2);

    // Interleaved CPU/dbg reads
    cycle(1, 1, 14'h0001, 32'h11111111, 0, 0, '0, '0);
    cycle(0, 0, '0, '0, 1, 1, 14'h0002, 32'h22222222);
    cycle(1, 0, 14'h0001, '0, 0, 0, '0, '0);
    cycle(0, 0, '0, '0, 1, 0, 14'h0002, '0);
    chk("il_cpu_rdata", cpu_rdata, 32'h11111111);
    cycle(0, 0, '0, '0, 0, 0, '0, '0);
    chk("il_dbg_rdata", dbg_rdata, 32'h22222222);
    chk("il_cpu_quiet", cpu_rvalid, 0);
    idle(2);
    chk("il_cpu_hold", cpu_rdata, 32'h11111111);
    chk("il_dbg_hold", dbg_rdata, 32'h22222222);

    // Starvation: both held high, dbg forced every MAXS+1 cycles
    for (int i = 0; i < 3 * (MAXS + 1); i++) begin
      cycle(1, 0, 14'(i), '0, 1, 1, 14'h0020, 32'hA5A5_0000);
      chk("starve_gnt", dbg_gnt, (i % (MAXS + 1)) == MAXS);
    end
    idle(2);

    // Reset between a dbg read grant and its return
    cycle(0, 0, '0, '0, 1, 0, 14'h0002, '0);
    chk("mr_gnt", dbg_gnt, 1);
    do_reset(3);
    cycle(0, 0, '0, '0, 1, 0, 14'h0001, '0);
    chk("mr_regrant", dbg_gnt, 1);
    idle(2);

    // Random traffic; both sides hold their request until granted
    c_hold = 0; d_hold = 0;
    for (int n = 0; n < 600; n++) begin
      if (!c_hold && ($urandom_range(0, 9) < 7)) begin
        c_hold = 1; c_we = $urandom_range(0, 1); c_addr = 14'($urandom_range(0, 15));
        c_wd = $urandom;
      end
      if (!d_hold && ($urandom_range(0, 9) < 5)) begin
        d_hold = 1; d_we = $urandom_range(0, 1); d_addr = 14'($urandom_range(0, 15));
        d_wd = $urandom;
      end
      cycle(c_hold, c_hold & c_we, c_hold ? c_addr : '0, c_hold ? c_wd : '0,
            d_hold, d_hold & d_we, d_hold ? d_addr : '0, d_hold ? d_wd : '0);
      if (e_cpu_win) c_hold = 0;
      if (e_dbg_win) d_hold = 0;
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
